riscv_core_mul_ctrl: RTL

//  Sequencer for the RV64M multiply group (MUL/MULH/MULHSU/MULHU/MULW) around the 64-cycle shift-add core.

---
 rtl/riscv_core_mul_pkg.sv | 32 +++
 rtl/riscv_core_booth.sv | 55 +++++
 rtl/riscv_core_mul_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/riscv_core_mul_pkg.sv
// Shared types and constants for the RV64M multiply sequencer and its shift-add core.
package riscv_core_mul_pkg;

    localparam int CORE_LAT = 64;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_FIXUP,
        ST_RESP
    } mulctl_state_e;

    // {a_signed, b_signed}; MUL and MULW produce sign-independent low bits, so both are unsigned.
    function automatic logic [1:0] sign_class(mul_op_e op, logic word);
        logic [1:0] cls;
        cls = 2'b00;
        if (!word) begin
            cls[1] = (op == OP_MULH) || (op == OP_MULHSU);
            cls[0] = (op == OP_MULH);
        end
        return cls;
    endfunction

endpackage

// File: rtl/riscv_core_booth.sv
// Unsigned 64-iteration shift-add multiplier; the first iteration happens on the enable edge.
module riscv_core_booth #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [XLEN-1:0]   mcand,
    input  logic [XLEN-1:0]   mplier,
    output logic              done,
    output logic [2*XLEN-1:0] product
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] src;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN:0]     sum;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;

    always_comb begin
        src      = en ? {{XLEN{1'b0}}, mplier} : acc_q;
        sum      = {1'b0, src[2*XLEN-1:XLEN]} + (src[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        acc_next = {sum, src[XLEN-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en) begin
                acc_q  <= acc_next;
                cnt_q  <= CW'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/riscv_core_mul_ctrl.sv
// RV64M multiply sequencer: magnitude conversion, shift-add core, sign fixup, result select.
// Optional MUL_FUSE_CACHE_EN keeps the last full product for back-to-back MULH*/MUL fusion.
module riscv_core_mul_ctrl #(
    parameter int XLEN     = 64,
    parameter int CORE_LAT = riscv_core_mul_pkg::CORE_LAT
) (
    input  logic            i_mulctl_clk,
    input  logic            i_mulctl_rst,
    input  logic            i_mulctl_flush,
    input  logic            i_mulctl_valid,
    output logic            o_mulctl_ready,
    input  logic [1:0]      i_mulctl_op,
    input  logic            i_mulctl_word,
    input  logic [XLEN-1:0] i_mulctl_rs1,
    input  logic [XLEN-1:0] i_mulctl_rs2,
    input  logic [4:0]      i_mulctl_rd,
    output logic            o_mulctl_valid,
    input  logic            i_mulctl_ready,
    output logic [XLEN-1:0] o_mulctl_result,
    output logic [4:0]      o_mulctl_rd,
    output logic            o_mulctl_busy
);
    import riscv_core_mul_pkg::*;

    mulctl_state_e     state_q, state_d;
    mul_op_e           op_in, op_q;
    logic [1:0]        cls_in;
    logic              word_q, neg_q, neg_in, zero_in, accept, hit, timeout;
    logic [XLEN-1:0]   a_in, b_in, a_mag_in, b_mag_in, a_mag_q, b_mag_q;
    logic [XLEN-1:0]   result_q, fix_result, fast_result;
    logic [4:0]        rd_q;
    logic [2*XLEN-1:0] prod_q, fixed;
    logic [7:0]        wait_cnt_q;
    logic              core_rst_n_q, core_en, core_done;
    logic [2*XLEN-1:0] core_product;

    always_comb begin
        op_in    = mul_op_e'(i_mulctl_op);
        cls_in   = sign_class(op_in, i_mulctl_word);
        a_in     = i_mulctl_word ? {{(XLEN-32){1'b0}}, i_mulctl_rs1[31:0]} : i_mulctl_rs1;
        b_in     = i_mulctl_word ? {{(XLEN-32){1'b0}}, i_mulctl_rs2[31:0]} : i_mulctl_rs2;
        a_mag_in = (cls_in[1] && a_in[XLEN-1]) ? -a_in : a_in;
        b_mag_in = (cls_in[0] && b_in[XLEN-1]) ? -b_in : b_in;
        neg_in   = (cls_in[1] & a_in[XLEN-1]) ^ (cls_in[0] & b_in[XLEN-1]);
        zero_in  = (a_in == '0) || (b_in == '0);
        accept   = i_mulctl_valid && (state_q == ST_IDLE) && !i_mulctl_flush;
        timeout  = ({24'd0, wait_cnt_q} > 32'(CORE_LAT + 2));
    end

`ifdef MUL_FUSE_CACHE_EN
    logic              cache_vld_q;
    logic [2*XLEN-1:0] cache_prod_q;
    logic [XLEN-1:0]   cache_a_q, cache_b_q, rs1_q, rs2_q;
    logic [1:0]        cache_cls_q, cls_q;

    always_comb begin
        hit = cache_vld_q && !i_mulctl_word && (i_mulctl_rs1 == cache_a_q) &&
              (i_mulctl_rs2 == cache_b_q) && ((cls_in == cache_cls_q) || (op_in == OP_MUL));
        fast_result = '0;
        if (hit)
            fast_result = (op_in == OP_MUL) ? cache_prod_q[XLEN-1:0] : cache_prod_q[2*XLEN-1:XLEN];
    end

    // NOTE: only the valid bit is reset; the payload is never read while it is clear.
    always_ff @(posedge i_mulctl_clk) begin
        if (i_mulctl_rst || i_mulctl_flush) begin
            cache_vld_q <= 1'b0;
        end else if (accept && i_mulctl_word) begin
            cache_vld_q <= 1'b0;
        end else if (state_q == ST_FIXUP && !word_q) begin
            cache_vld_q  <= 1'b1;
            cache_prod_q <= fixed;
            cache_a_q    <= rs1_q;
            cache_b_q    <= rs2_q;
            cache_cls_q  <= cls_q;
        end
        if (accept) begin
            rs1_q <= i_mulctl_rs1;
            rs2_q <= i_mulctl_rs2;
            cls_q <= cls_in;
        end
    end
`else
    always_comb begin
        hit         = 1'b0;
        fast_result = '0;
    end
`endif

    always_comb begin
        fixed = neg_q ? -prod_q : prod_q;
        if (word_q)
            fix_result = {{(XLEN-32){fixed[31]}}, fixed[31:0]};
        else if (op_q == OP_MUL)
            fix_result = fixed[XLEN-1:0];
        else
            fix_result = fixed[2*XLEN-1:XLEN];
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        core_en = 1'b0;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (zero_in || hit) ? ST_RESP : ST_START;
            ST_START: begin
                core_en = !i_mulctl_flush;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done)    state_d = ST_FIXUP;
                else if (timeout) state_d = ST_RESP;
            end
            ST_FIXUP: state_d = ST_RESP;
            ST_RESP:  if (i_mulctl_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (i_mulctl_flush) state_d = ST_IDLE;
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge i_mulctl_clk) begin
        if (i_mulctl_rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_MUL;
            word_q       <= 1'b0;
            neg_q        <= 1'b0;
            rd_q         <= '0;
            a_mag_q      <= '0;
            b_mag_q      <= '0;
            prod_q       <= '0;
            result_q     <= '0;
            wait_cnt_q   <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_rst_n_q <= !i_mulctl_flush;
            wait_cnt_q   <= (state_q == ST_WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
            if (accept) begin
                op_q     <= op_in;
                word_q   <= i_mulctl_word;
                rd_q     <= i_mulctl_rd;
                a_mag_q  <= a_mag_in;
                b_mag_q  <= b_mag_in;
                neg_q    <= neg_in;
                result_q <= fast_result;
            end
            if (state_q == ST_WAIT && core_done)
                prod_q <= core_product;
            if (state_q == ST_FIXUP)
                result_q <= fix_result;
            else if (state_q == ST_WAIT && timeout && !core_done)
                result_q <= '0;
            if (state_q == ST_WAIT)
                assert (!timeout || core_done);
        end
    end

    // Multiplicand stays in a_mag_q for the whole WAIT phase; the core reads it every iteration.
    riscv_core_booth #(.XLEN(XLEN)) u_core (
        .clk     (i_mulctl_clk),
        .rst_n   (core_rst_n_q),
        .en      (core_en),
        .mcand   (a_mag_q),
        .mplier  (b_mag_q),
        .done    (core_done),
        .product (core_product)
    );

    assign o_mulctl_ready  = (state_q == ST_IDLE);
    assign o_mulctl_valid  = (state_q == ST_RESP);
    assign o_mulctl_busy   = (state_q != ST_IDLE);
    assign o_mulctl_result = result_q;
    assign o_mulctl_rd     = rd_q;

endmodule
